spw_rx_sync: RTL and testbench
==============================

Name: spw_rx_sync

Overview:
- Next-generation SpaceWire receiver. Samples the Data-Strobe pair with a local system clock instead of recovering a clock from the link.
- Assembles characters through an explicit FSM and checks parity.
- Decodes NULL, FCT, EOP, EEP, N-Char and Time-Code; detects escape and disconnect errors.
- Buffers N-Chars in a parametrised FIFO toward the link/host side of the codec.

Parameters:
SYNC_STAGES, 2, synchroniser flops on rx_din/rx_sin (min 2)
DISC_CYCLES, 85, clk cycles without a DS edge that signal disconnect (850 ns at 100 MHz)
FIFO_DEPTH, 16, N-Char buffer entries (power of 2, >=2)
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock; must give >=3 clk per DS bit
rx_resetn  in  1  reset
rx_din  in  1  async SpaceWire data line
rx_sin  in  1  async SpaceWire strobe line
rx_enable  in  1  receiver enable; deassert clears the error state
rx_rd  in  1  FIFO pop
rx_data_flag  out  9  FIFO head: [8]=1 control (EOP/EEP), [7:0] data or 0x00=EOP / 0x01=EEP
rx_empty  out  1  FIFO empty
rx_fifo_count  out  ADDR_W+1  entries held
rx_got_bit  out  1  pulse: DS edge seen
rx_got_null  out  1  pulse
rx_got_fct  out  1  pulse
rx_got_nchar  out  1  pulse
rx_tick_out  out  1  pulse: time-code received
rx_time_out  out  8  last time-code value
rx_err_parity  out  1  sticky
rx_err_esc  out  1  sticky
rx_err_disc  out  1  sticky
rx_err_ovf  out  1  sticky: N-Char dropped because FIFO full

Behaviour:
- Reset is asynchronous, active-low on rx_resetn. All outputs reset to 0, except rx_empty=1. FSM resets to S_OFF, FIFO pointers to 0.
- Sync and edge detection:
  - din/sin each pass through SYNC_STAGES flops, then one history flop.
  - A bit is received when the synced din or sin differs from its history; that cycle asserts rx_got_bit.
  - Bit value is the synced din.
- FSM states:
  - S_OFF: wait rx_enable=1 -> S_HDR.
  - S_HDR: 2 bits, parity P then flag F. F=1 -> S_CTRL, else S_DATA.
  - S_CTRL: 2 bits, LSB first; code 0=FCT, 1=EOP, 2=EEP, 3=ESC -> S_HDR.
  - S_DATA: 8 bits, LSB first -> S_HDR.
  - S_ERR: any error; hold until rx_enable=0, then S_OFF. Sticky error flags clear on the S_ERR->S_OFF transition.
  - rx_enable=0 in any state -> S_OFF at the next clk; partial character discarded.
- Parity (odd):
  - XOR of the previous character's data/control bits, the current P and the current F must equal 1.
  - Not checked on the first character after S_OFF.
  - Failure -> rx_err_parity=1, S_ERR; that character is not decoded.
- Gating:
  - Until the first NULL after S_OFF, no pulse and no FIFO write for any character.
  - The NULL itself pulses rx_got_null.
- Escape handling:
  - ESC followed by FCT: NULL.
  - ESC followed by a data char: time-code. rx_time_out is loaded with that byte and rx_tick_out pulses; the byte is not written to the FIFO.
  - ESC followed by ESC, EOP or EEP: rx_err_esc=1, S_ERR.
- Timing:
  - Pulses are asserted exactly 1 clk after the clk in which the final bit of the character is detected, and last 1 clk.
  - A FIFO write occurs in the same cycle as rx_got_nchar.
- FIFO:
  - First-word fall-through. rx_data_flag is valid whenever rx_empty=0.
  - rx_rd while rx_empty=1 is ignored.
  - A write while full and rx_rd=0: character dropped, rx_err_ovf=1. FSM continues; overflow is not a link error.
  - Simultaneous rd+wr while full: both succeed, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO contents survive S_ERR and S_OFF; only rx_resetn empties it.
- Disconnect:
  - A counter increments each clk without a bit and clears on each bit.
  - Armed after the first bit following S_OFF.
  - Reaching DISC_CYCLES -> rx_err_disc=1, S_ERR.

Test Plan:
- Enable, then send NULL,NULL,FCT: first NULL pulses rx_got_null (gating released), second NULL pulses rx_got_null, then rx_got_fct=1 once; FIFO stays empty.
- After NULL, send data 0xA5, then EOP, then pop twice: rx_data_flag=0x0A5, then 0x100; rx_fifo_count goes 2->1->0; rx_empty=1 after the second pop.
- ESC + data 0x3F: rx_tick_out=1 for one clk, rx_time_out=0x3F, no FIFO write. ESC+EOP: rx_err_esc=1; output pulses stop until rx_enable toggles.
- Corrupt the parity bit of the 3rd character: rx_err_parity=1; that character is not decoded, no further pulses; drop rx_enable, then re-enable: flag clears.
- With FIFO_DEPTH=16, write 17 data chars with no pops: count=16, rx_err_ovf=1, the 17th is lost; 16 pops return the first 16 in order.
- Stop DS toggling for DISC_CYCLES clk after link activity: rx_err_disc=1 at exactly cycle DISC_CYCLES. Assert rx_resetn low mid-character: all outputs reset immediately, rx_empty=1.

Source files
------------

// File: rtl/spw_rx_sync.sv
// SpaceWire receiver that oversamples the Data-Strobe pair with the system clock.
// Assembles characters, checks odd parity, decodes control codes and buffers N-Chars (FWFT).
module spw_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DISC_CYCLES = 85,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic            clk,
  input  logic            rx_resetn,
  input  logic            rx_din,
  input  logic            rx_sin,
  input  logic            rx_enable,
  input  logic            rx_rd,
  output logic [8:0]      rx_data_flag,
  output logic            rx_empty,
  output logic [ADDR_W:0] rx_fifo_count,
  output logic            rx_got_bit,
  output logic            rx_got_null,
  output logic            rx_got_fct,
  output logic            rx_got_nchar,
  output logic            rx_tick_out,
  output logic [7:0]      rx_time_out,
  output logic            rx_err_parity,
  output logic            rx_err_esc,
  output logic            rx_err_disc,
  output logic            rx_err_ovf
);

  localparam int unsigned DiscW = $clog2(DISC_CYCLES + 1);
  localparam int unsigned CntW  = ADDR_W + 1;

  localparam logic [1:0] CodeFct = 2'd0;
  localparam logic [1:0] CodeEop = 2'd1;
  localparam logic [1:0] CodeEep = 2'd2;

  typedef enum logic [2:0] {StOff, StHdr, StCtrl, StData, StErr} state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and DS edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] din_sync_q, sin_sync_q;
  logic                   din_hist_q, sin_hist_q;
  logic                   din_s, sin_s, bit_valid;

  always_ff @(posedge clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      din_sync_q <= '0;
      sin_sync_q <= '0;
      din_hist_q <= 1'b0;
      sin_hist_q <= 1'b0;
    end else begin
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], rx_din};
      sin_sync_q <= {sin_sync_q[SYNC_STAGES-2:0], rx_sin};
      din_hist_q <= din_sync_q[SYNC_STAGES-1];
      sin_hist_q <= sin_sync_q[SYNC_STAGES-1];
    end
  end

  assign din_s      = din_sync_q[SYNC_STAGES-1];
  assign sin_s      = sin_sync_q[SYNC_STAGES-1];
  assign bit_valid  = (din_s != din_hist_q) || (sin_s != sin_hist_q);
  assign rx_got_bit = bit_valid;

  // ---------------------------------------------------------------------------
  // Character FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_bit_q, par_bit_d;
  logic             par_acc_q, par_acc_d;
  logic [7:0]       shift_q, shift_d;
  logic             first_q, first_d;
  logic             null_seen_q, null_seen_d;
  logic             esc_q, esc_d;
  logic             armed_q, armed_d;
  logic [DiscW-1:0] disc_cnt_q, disc_cnt_d;
  logic [7:0]       time_q, time_d;
  logic [8:0]       nchar_q, nchar_d;
  logic             got_null_q, got_null_d;
  logic             got_fct_q, got_fct_d;
  logic             got_nchar_q, got_nchar_d;
  logic             tick_q, tick_d;
  logic             err_par_q, err_par_d;
  logic             err_esc_q, err_esc_d;
  logic             err_disc_q, err_disc_d;
  logic             err_clr;
  logic [1:0]       ctrl_code;
  logic [7:0]       data_byte;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    par_bit_d   = par_bit_q;
    par_acc_d   = par_acc_q;
    shift_d     = shift_q;
    first_d     = first_q;
    null_seen_d = null_seen_q;
    esc_d       = esc_q;
    armed_d     = armed_q;
    disc_cnt_d  = disc_cnt_q;
    time_d      = time_q;
    nchar_d     = nchar_q;
    got_null_d  = 1'b0;
    got_fct_d   = 1'b0;
    got_nchar_d = 1'b0;
    tick_d      = 1'b0;
    err_par_d   = err_par_q;
    err_esc_d   = err_esc_q;
    err_disc_d  = err_disc_q;
    err_clr     = 1'b0;
    ctrl_code   = {din_s, shift_q[0]};
    data_byte   = {din_s, shift_q[7:1]};

    if (!rx_enable) begin
      state_d = StOff;
      if (state_q == StErr) begin
        err_clr    = 1'b1;
        err_par_d  = 1'b0;
        err_esc_d  = 1'b0;
        err_disc_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StOff: begin
          state_d     = StHdr;
          bit_cnt_d   = 3'd0;
          par_acc_d   = 1'b0;
          first_d     = 1'b1;
          null_seen_d = 1'b0;
          esc_d       = 1'b0;
          armed_d     = 1'b0;
          disc_cnt_d  = '0;
        end
        StHdr, StCtrl, StData: begin
          if (bit_valid) begin
            armed_d    = 1'b1;
            disc_cnt_d = '0;
          end else if (armed_q) begin
            if (disc_cnt_q == DiscW'(DISC_CYCLES - 1)) begin
              err_disc_d = 1'b1;
              state_d    = StErr;
            end else begin
              disc_cnt_d = disc_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (bit_valid) begin
        unique case (state_q)
          StHdr: begin
            if (bit_cnt_q == 3'd0) begin
              par_bit_d = din_s;
              bit_cnt_d = 3'd1;
            end else begin
              bit_cnt_d = 3'd0;
              // Odd parity spans the previous character's payload plus this P and F.
              if (!first_q && !(par_acc_q ^ par_bit_q ^ din_s)) begin
                err_par_d = 1'b1;
                state_d   = StErr;
              end else begin
                first_d   = 1'b0;
                par_acc_d = 1'b0;
                state_d   = din_s ? StCtrl : StData;
              end
            end
          end
          StCtrl: begin
            par_acc_d = par_acc_q ^ din_s;
            if (bit_cnt_q == 3'd0) begin
              shift_d[0] = din_s;
              bit_cnt_d  = 3'd1;
            end else begin
              bit_cnt_d = 3'd0;
              state_d   = StHdr;
              if (esc_q) begin
                esc_d = 1'b0;
                if (ctrl_code == CodeFct) begin
                  null_seen_d = 1'b1;
                  got_null_d  = 1'b1;
                end else begin
                  err_esc_d = 1'b1;
                  state_d   = StErr;
                end
              end else begin
                case (ctrl_code)
                  CodeFct: got_fct_d = null_seen_q;
                  CodeEop: begin
                    if (null_seen_q) begin
                      got_nchar_d = 1'b1;
                      nchar_d     = 9'h100;
                    end
                  end
                  CodeEep: begin
                    if (null_seen_q) begin
                      got_nchar_d = 1'b1;
                      nchar_d     = 9'h101;
                    end
                  end
                  default: esc_d = 1'b1;
                endcase
              end
            end
          end
          StData: begin
            par_acc_d = par_acc_q ^ din_s;
            shift_d   = data_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = StHdr;
              if (esc_q) begin
                esc_d = 1'b0;
                if (null_seen_q) begin
                  tick_d = 1'b1;
                  time_d = data_byte;
                end
              end else if (null_seen_q) begin
                got_nchar_d = 1'b1;
                nchar_d     = {1'b0, data_byte};
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state_q     <= StOff;
      bit_cnt_q   <= 3'd0;
      par_bit_q   <= 1'b0;
      par_acc_q   <= 1'b0;
      shift_q     <= 8'h00;
      first_q     <= 1'b1;
      null_seen_q <= 1'b0;
      esc_q       <= 1'b0;
      armed_q     <= 1'b0;
      disc_cnt_q  <= '0;
      time_q      <= 8'h00;
      nchar_q     <= 9'h000;
      got_null_q  <= 1'b0;
      got_fct_q   <= 1'b0;
      got_nchar_q <= 1'b0;
      tick_q      <= 1'b0;
      err_par_q   <= 1'b0;
      err_esc_q   <= 1'b0;
      err_disc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      par_bit_q   <= par_bit_d;
      par_acc_q   <= par_acc_d;
      shift_q     <= shift_d;
      first_q     <= first_d;
      null_seen_q <= null_seen_d;
      esc_q       <= esc_d;
      armed_q     <= armed_d;
      disc_cnt_q  <= disc_cnt_d;
      time_q      <= time_d;
      nchar_q     <= nchar_d;
      got_null_q  <= got_null_d;
      got_fct_q   <= got_fct_d;
      got_nchar_q <= got_nchar_d;
      tick_q      <= tick_d;
      err_par_q   <= err_par_d;
      err_esc_q   <= err_esc_d;
      err_disc_q  <= err_disc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // N-Char FIFO, written in the cycle rx_got_nchar is high
  // ---------------------------------------------------------------------------
  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              fifo_full, fifo_empty, rd_en, wr_en;
  logic              err_ovf_q;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign rd_en      = rx_rd && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en      = got_nchar_q && (!fifo_full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= nchar_q;
    end
  end

  always_ff @(posedge clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count_q <= count_q + 1'b1;
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - 1'b1;
      end
      if (err_clr) begin
        err_ovf_q <= 1'b0;
      end else if (got_nchar_q && !wr_en) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  assign rx_data_flag  = fifo_empty ? 9'h000 : mem_q[rd_ptr_q];
  assign rx_empty      = fifo_empty;
  assign rx_fifo_count = count_q;
  assign rx_got_null   = got_null_q;
  assign rx_got_fct    = got_fct_q;
  assign rx_got_nchar  = got_nchar_q;
  assign rx_tick_out   = tick_q;
  assign rx_time_out   = time_q;
  assign rx_err_parity = err_par_q;
  assign rx_err_esc    = err_esc_q;
  assign rx_err_disc   = err_disc_q;
  assign rx_err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_spw_rx_sync.sv
// Bench for spw_rx_sync: DS-encoded character stimulus checked against a
// character-level model of the receiver (gating, escapes, errors, FIFO queue).
module tb_spw_rx_sync;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned DiscCycles = 85;
  localparam int unsigned FifoDepth  = 16;
  localparam int unsigned AddrW      = 4;
  localparam int unsigned BitClks    = 4;

  logic             clk = 1'b0;
  logic             rx_resetn;
  logic             rx_din, rx_sin, rx_enable, rx_rd;
  logic [8:0]       rx_data_flag;
  logic             rx_empty;
  logic [AddrW:0]   rx_fifo_count;
  logic             rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_tick_out;
  logic [7:0]       rx_time_out;
  logic             rx_err_parity, rx_err_esc, rx_err_disc, rx_err_ovf;

  spw_rx_sync #(
    .SYNC_STAGES(SyncStages),
    .DISC_CYCLES(DiscCycles),
    .FIFO_DEPTH (FifoDepth),
    .ADDR_W     (AddrW)
  ) dut (
    .clk          (clk),
    .rx_resetn    (rx_resetn),
    .rx_din       (rx_din),
    .rx_sin       (rx_sin),
    .rx_enable    (rx_enable),
    .rx_rd        (rx_rd),
    .rx_data_flag (rx_data_flag),
    .rx_empty     (rx_empty),
    .rx_fifo_count(rx_fifo_count),
    .rx_got_bit   (rx_got_bit),
    .rx_got_null  (rx_got_null),
    .rx_got_fct   (rx_got_fct),
    .rx_got_nchar (rx_got_nchar),
    .rx_tick_out  (rx_tick_out),
    .rx_time_out  (rx_time_out),
    .rx_err_parity(rx_err_parity),
    .rx_err_esc   (rx_err_esc),
    .rx_err_disc  (rx_err_disc),
    .rx_err_ovf   (rx_err_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse monitor: counts pulses and checks they follow a detected bit by one clock.
  int   cyc = 0;
  int   last_bit_cyc = 0;
  int   mon_null = 0, mon_fct = 0, mon_nchar = 0, mon_tick = 0;
  logic prev_bit = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rx_resetn) begin
      prev_bit = 1'b0;
    end else begin
      if (rx_got_null || rx_got_fct || rx_got_nchar || rx_tick_out)
        chk("pulse_latency", {31'd0, prev_bit}, 32'd1);
      mon_null  += int'(rx_got_null);
      mon_fct   += int'(rx_got_fct);
      mon_nchar += int'(rx_got_nchar);
      mon_tick  += int'(rx_tick_out);
      if (rx_got_bit) last_bit_cyc = cyc;
      prev_bit = rx_got_bit;
    end
  end

  // Character-level reference model
  logic       m_en = 0, m_err = 0, m_first = 1, m_null = 0, m_esc = 0;
  int         exp_null = 0, exp_fct = 0, exp_nchar = 0, exp_tick = 0;
  logic [7:0] exp_time = 8'h00;
  logic       exp_par = 0, exp_esc = 0, exp_disc = 0, exp_ovf = 0;
  logic [8:0] q[$];

  task automatic model_push(input logic [8:0] v);
    exp_nchar++;
    if (q.size() == FifoDepth) exp_ovf = 1'b1;
    else q.push_back(v);
  endtask

  task automatic model_char(input logic is_ctrl, input logic [7:0] val, input logic bad);
    if (!m_en || m_err) return;
    if (bad && !m_first) begin
      exp_par = 1'b1;
      m_err   = 1'b1;
      return;
    end
    m_first = 1'b0;
    if (m_esc) begin
      m_esc = 1'b0;
      if (is_ctrl) begin
        if (val[1:0] == 2'd0) begin
          m_null = 1'b1;
          exp_null++;
        end else begin
          exp_esc = 1'b1;
          m_err   = 1'b1;
        end
      end else if (m_null) begin
        exp_tick++;
        exp_time = val;
      end
    end else if (is_ctrl) begin
      case (val[1:0])
        2'd0:    if (m_null) exp_fct++;
        2'd1:    if (m_null) model_push(9'h100);
        2'd2:    if (m_null) model_push(9'h101);
        default: m_esc = 1'b1;
      endcase
    end else if (m_null) begin
      model_push({1'b0, val});
    end
  endtask

  // DS transmitter: exactly one of D/S changes per bit
  logic d_line = 1'b0, s_line = 1'b0, tx_prev = 1'b0;

  task automatic send_bit(input logic b);
    if (b != d_line) d_line = b;
    else s_line = ~s_line;
    rx_din = d_line;
    rx_sin = s_line;
    repeat (BitClks) @(negedge clk);
  endtask

  task automatic send_char(input logic is_ctrl, input logic [7:0] val, input logic bad);
    int   n;
    logic x;
    n = is_ctrl ? 2 : 8;
    x = 1'b0;
    for (int i = 0; i < n; i++) x ^= val[i];
    send_bit(1'b1 ^ tx_prev ^ is_ctrl ^ bad);
    send_bit(is_ctrl);
    for (int i = 0; i < n; i++) send_bit(val[i]);
    tx_prev = x;
    model_char(is_ctrl, val, bad);
  endtask

  task automatic send_fct();              send_char(1'b1, 8'd0, 1'b0); endtask
  task automatic send_eop();              send_char(1'b1, 8'd1, 1'b0); endtask
  task automatic send_eep();              send_char(1'b1, 8'd2, 1'b0); endtask
  task automatic send_esc();              send_char(1'b1, 8'd3, 1'b0); endtask
  task automatic send_data(input logic [7:0] v); send_char(1'b0, v, 1'b0); endtask
  task automatic send_null();             send_esc(); send_fct(); endtask
  task automatic send_time(input logic [7:0] v); send_esc(); send_data(v); endtask

  task automatic set_enable(input logic v);
    @(negedge clk);
    rx_enable = v;
    if (v) begin
      m_en = 1'b1; m_first = 1'b1; m_null = 1'b0; m_esc = 1'b0;
    end else begin
      m_en = 1'b0;
      if (m_err) begin
        exp_par = 0; exp_esc = 0; exp_disc = 0; exp_ovf = 0;
      end
      m_err = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    repeat (8) @(negedge clk);
    #1;
    chk({tag, ".null"},  mon_null,  exp_null);
    chk({tag, ".fct"},   mon_fct,   exp_fct);
    chk({tag, ".nchar"}, mon_nchar, exp_nchar);
    chk({tag, ".tick"},  mon_tick,  exp_tick);
    chk({tag, ".time"},  {24'd0, rx_time_out}, {24'd0, exp_time});
    chk({tag, ".count"}, {27'd0, rx_fifo_count}, q.size());
    chk({tag, ".empty"}, {31'd0, rx_empty}, {31'd0, (q.size() == 0)});
    chk({tag, ".err_par"},  {31'd0, rx_err_parity}, {31'd0, exp_par});
    chk({tag, ".err_esc"},  {31'd0, rx_err_esc},    {31'd0, exp_esc});
    chk({tag, ".err_disc"}, {31'd0, rx_err_disc},   {31'd0, exp_disc});
    chk({tag, ".err_ovf"},  {31'd0, rx_err_ovf},    {31'd0, exp_ovf});
  endtask

  task automatic pop_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk({tag, ".pop_count"}, {27'd0, rx_fifo_count}, q.size());
      chk({tag, ".pop_empty"}, {31'd0, rx_empty}, {31'd0, (q.size() == 0)});
      if (q.size() > 0) chk({tag, ".pop_head"}, {23'd0, rx_data_flag}, {23'd0, q[0]});
      rx_rd = 1'b1;
      @(posedge clk);
      #1;
      rx_rd = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  task automatic pop_all(input string tag);
    pop_n(tag, q.size());
    @(negedge clk);
    #1;
    chk({tag, ".drained_empty"}, {31'd0, rx_empty}, 32'd1);
    chk({tag, ".drained_count"}, {27'd0, rx_fifo_count}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".flag"},  {23'd0, rx_data_flag}, 32'd0);
    chk({tag, ".empty"}, {31'd0, rx_empty}, 32'd1);
    chk({tag, ".count"}, {27'd0, rx_fifo_count}, 32'd0);
    chk({tag, ".pulses"},
        {27'd0, rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_tick_out}, 32'd0);
    chk({tag, ".time"},  {24'd0, rx_time_out}, 32'd0);
    chk({tag, ".errs"},
        {28'd0, rx_err_parity, rx_err_esc, rx_err_disc, rx_err_ovf}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int r;
    rx_resetn = 1'b0;
    rx_din    = 1'b0;
    rx_sin    = 1'b0;
    rx_enable = 1'b0;
    rx_rd     = 1'b0;
    #1;
    check_reset("reset");
    repeat (3) @(negedge clk);
    rx_resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Gating: nothing before the first NULL, then NULL, NULL, FCT
    set_enable(1'b1);
    send_fct();
    send_data(8'h12);
    send_null();
    send_null();
    send_fct();
    check_all("gate");

    // Data then EOP, popped in order
    send_data(8'hA5);
    send_eop();
    check_all("a5_eop");
    pop_all("a5_eop");

    // Time-code
    send_time(8'h3F);
    check_all("tcode");

    // Random legal traffic
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 10; k++) begin
        r = int'($urandom_range(0, 5));
        case (r)
          0: send_null();
          1: send_fct();
          2: send_data(8'($urandom));
          3: send_eop();
          4: send_eep();
          default: send_time(8'($urandom));
        endcase
      end
      check_all("rand");
      pop_all("rand");
    end

    // ESC followed by EOP is an escape error; decoding stops until re-enable
    send_esc();
    send_eop();
    send_null();
    send_data(8'h77);
    check_all("esc_err");
    set_enable(1'b0);
    check_all("esc_clr");
    set_enable(1'b1);

    // Third character carries a bad parity bit
    send_null();
    send_char(1'b0, 8'h55, 1'b1);
    send_null();
    check_all("par_err");
    set_enable(1'b0);
    check_all("par_clr");
    set_enable(1'b1);

    // Overflow: 17 data characters into a 16-entry FIFO
    send_null();
    for (int i = 0; i < 17; i++) send_data(8'($urandom));
    check_all("ovf");
    pop_n("ovf", 15);

    // Disconnect: flag rises after DiscCycles clocks with no bit
    guard = 0;
    while ((cyc - last_bit_cyc) < int'(DiscCycles) && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("disc.gap", cyc - last_bit_cyc, DiscCycles);
    chk("disc.before", {31'd0, rx_err_disc}, 32'd0);
    @(negedge clk);
    #1;
    chk("disc.at", {31'd0, rx_err_disc}, 32'd1);
    exp_disc = 1'b1;
    m_err    = 1'b1;
    check_all("disc");
    set_enable(1'b0);
    check_all("disc_clr");
    pop_all("disc_clr");

    // Asynchronous reset in the middle of a character
    set_enable(1'b1);
    send_null();
    send_data(8'h44);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    #2;
    rx_resetn = 1'b0;
    #1;
    check_reset("midrst");
    q.delete();
    repeat (2) @(negedge clk);
    rx_resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
